// File: rtl/if_pc_control.sv
// IF-stage program-counter controller: PC register, next-PC selection and fetch sequencing.
// Optional single-step mode is enabled by defining IF_PC_STEP_EN.
module if_pc_control #(
    parameter int          NB_PC      = 32,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [NB_PC-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NB_PC-1:0] i_jump_target,
    input  logic [31:0]      i_instruction,
    output logic [NB_PC-1:0] o_PC,
    output logic             o_advance,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [31:0]      o_cycle_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            halted_q;
    logic            armed_q;
    logic            advance;
    logic            hit_halt;

`ifdef IF_PC_STEP_EN
    assign advance = !i_reset && ((state_q == S_RUN) || ((state_q == S_STEP) && i_step));
    logic unused_bits;
    assign unused_bits = ^{i_branch_target[NB_PC-1:AW], i_jump_target[NB_PC-1:AW]};
`else
    assign advance = !i_reset && (state_q == S_RUN);
    logic unused_bits;
    assign unused_bits = ^{i_branch_target[NB_PC-1:AW], i_jump_target[NB_PC-1:AW],
                           i_mode, i_step};
`endif

    // Next PC: jump > branch > stall > halt word > increment; a taken jump/branch squashes the halt word.
    always_comb begin
        pc_d     = pc_q;
        hit_halt = 1'b0;
        if (advance) begin
            if (i_jump)
                pc_d = i_jump_target[AW-1:0];
            else if (i_branch_taken)
                pc_d = i_branch_target[AW-1:0];
            else if (i_stall)
                pc_d = pc_q;
            else if (i_instruction == HALT_WORD)
                hit_halt = 1'b1;
            else
                pc_d = pc_q + AW'(1);
        end
    end

    assign cnt_d = (advance && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;

    // armed_q blocks a start request sampled on the first edge after reset release.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (i_start && armed_q) begin
`ifdef IF_PC_STEP_EN
                        state_q <= i_mode ? S_STEP : S_RUN;
`else
                        state_q <= S_RUN;
`endif
                    end
                end
                S_RUN, S_STEP: begin
                    if (hit_halt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end

    assign o_PC          = NB_PC'(pc_q);
    assign o_advance     = advance;
    assign o_halted      = halted_q;
    assign o_state       = state_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_if_pc_control.sv
// Self-checking bench for if_pc_control: vector table, hand sequences and a randomized model run.
module tb_if_pc_control;

    logic        clk = 1'b0;
    logic        rst, start, mode, step, stall, br, jmp;
    logic [31:0] bt, jt, instr;
    logic [31:0] pc, cnt;
    logic        adv, halted;
    logic [1:0]  state;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    if_pc_control dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .i_stall(stall), .i_branch_taken(br), .i_branch_target(bt),
        .i_jump(jmp), .i_jump_target(jt), .i_instruction(instr),
        .o_PC(pc), .o_advance(adv), .o_halted(halted), .o_state(state),
        .o_cycle_count(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] instr;
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[20];

    // Reference model state
    int          m_pc;
    int          m_state;
    longint      m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; mode = 0; step = 0; stall = 0; br = 0; jmp = 0;
        bt = 0; jt = 0; instr = 32'h0000_0013;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        m_pc = 0; m_state = 0; m_cnt = 0;
    endtask

    task automatic start_run();
        start = 1; mode = 0;
        tick();
        start = 0;
        m_state = 1;
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] btv,
                                input logic j, input logic [31:0] jtv, input logic [31:0] ins,
                                input logic [31:0] epc, input logic [1:0] est);
        vec_t v;
        v.stall = s; v.br = b; v.bt = btv; v.jmp = j; v.jt = jtv;
        v.instr = ins; v.exp_pc = epc; v.exp_state = est;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 0,      0, 0,      0,  32'h01, 2'd1);
        vecs[1]  = mk(0, 0, 0,      0, 0,      0,  32'h02, 2'd1);
        vecs[2]  = mk(0, 0, 0,      0, 0,      0,  32'h03, 2'd1);
        vecs[3]  = mk(1, 0, 0,      0, 0,      0,  32'h03, 2'd1);
        vecs[4]  = mk(1, 1, 32'h40, 0, 0,      0,  32'h40, 2'd1);
        vecs[5]  = mk(1, 1, 32'h40, 1, 32'h20, 0,  32'h20, 2'd1);
        vecs[6]  = mk(0, 1, 32'h1FF, 0, 0,     0,  32'hFF, 2'd1);
        vecs[7]  = mk(0, 0, 0,      0, 0,      0,  32'h00, 2'd1);
        vecs[8]  = mk(0, 0, 0,      1, 32'h105, 0, 32'h05, 2'd1);
        vecs[9]  = mk(1, 0, 0,      0, 0,      0,  32'h05, 2'd1);
        vecs[10] = mk(1, 0, 0,      0, 0,      0,  32'h05, 2'd1);
        vecs[11] = mk(0, 0, 0,      0, 0,      0,  32'h06, 2'd1);
        vecs[12] = mk(0, 0, 0,      1, 32'h08, 0,  32'h08, 2'd1);
        vecs[13] = mk(1, 1, 32'h40, 1, 32'h20, 0,  32'h20, 2'd1);
        vecs[14] = mk(0, 0, 0,      1, 32'h08, 0,  32'h08, 2'd1);
        vecs[15] = mk(1, 1, 32'h40, 0, 0,      0,  32'h40, 2'd1);
        vecs[16] = mk(0, 1, 32'h10, 0, 0,      HW, 32'h10, 2'd1);
        vecs[17] = mk(1, 0, 0,      0, 0,      HW, 32'h10, 2'd1);
        vecs[18] = mk(0, 0, 0,      1, 32'h03, 0,  32'h03, 2'd1);
        vecs[19] = mk(0, 0, 0,      0, 0,      HW, 32'h03, 2'd3);

        clear_inputs();
        rst = 1;
        #2;
        check("reset_pc", pc, 0);
        check("reset_state", {30'd0, state}, 0);
        check("reset_cnt", cnt, 0);
        check("reset_adv", {31'd0, adv}, 0);
        check("reset_halted", {31'd0, halted}, 0);

        // Start pulse coincident with reset release is ignored.
        tick();
        rst = 0; start = 1;
        tick();
        start = 0;
        check("start_at_release_ignored", {30'd0, state}, 0);
        tick();
        check("idle_pc_hold", pc, 0);

        // Table-driven sequence from PC=0 in RUN.
        do_reset();
        start_run();
        check("start_state_run", {30'd0, state}, 1);
        check("start_no_advance_pc", pc, 0);
        check("start_no_advance_cnt", cnt, 0);
        for (int i = 0; i < 20; i++) begin
            stall = vecs[i].stall; br = vecs[i].br; bt = vecs[i].bt;
            jmp = vecs[i].jmp; jt = vecs[i].jt; instr = vecs[i].instr;
            #1;
            check($sformatf("vec%0d_adv", i), {31'd0, adv}, 1);
            tick();
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].exp_state});
            check($sformatf("vec%0d_cnt", i), cnt, i + 1);
            $display("vec %0d: pc=%0h state=%0d cnt=%0d", i, pc, state, cnt);
        end

        // Halted is sticky: later requests do nothing.
        check("halt_flag", {31'd0, halted}, 1);
        check("halt_adv", {31'd0, adv}, 0);
        clear_inputs();
        jmp = 1; jt = 32'h30; br = 1; bt = 32'h50; start = 1;
        tick(); tick();
        check("halted_pc_hold", pc, 3);
        check("halted_state", {30'd0, state}, 3);
        check("halted_cnt_frozen", cnt, 20);
        check("halted_adv_zero", {31'd0, adv}, 0);

        // Asynchronous reset mid-run at PC=0x17.
        do_reset();
        start_run();
        jmp = 1; jt = 32'h17;
        tick();
        jmp = 0;
        tick();
        check("pre_reset_pc", pc, 32'h18);
        #2 rst = 1;
        #1;
        check("async_rst_pc", pc, 0);
        check("async_rst_state", {30'd0, state}, 0);
        check("async_rst_cnt", cnt, 0);
        check("async_rst_adv", {31'd0, adv}, 0);
        $display("async reset: pc=%0h state=%0d cnt=%0d", pc, state, cnt);

`ifdef IF_PC_STEP_EN
        do_reset();
        start = 1; mode = 1;
        tick();
        start = 0; mode = 0;
        check("step_state", {30'd0, state}, 2);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) start = 1;
            #1;
            check("step_idle_adv", {31'd0, adv}, 0);
            tick();
            start = 0;
        end
        check("step_idle_pc", pc, 0);
        check("step_ignores_start", {30'd0, state}, 2);
        for (int i = 0; i < 3; i++) begin
            step = 1;
            #1;
            check("step_pulse_adv", {31'd0, adv}, 1);
            tick();
            step = 0;
            tick();
            $display("step %0d: pc=%0h cnt=%0d", i, pc, cnt);
        end
        check("step_pc", pc, 3);
        check("step_cnt", cnt, 3);
`else
        do_reset();
        start = 1; mode = 1;
        tick();
        start = 0; mode = 0;
        check("mode1_enters_run", {30'd0, state}, 1);
`endif

        // Randomized run against the reference model.
        do_reset();
        start_run();
        for (int i = 0; i < 400; i++) begin
            logic exp_adv;
            stall = ($urandom_range(0, 99) < 30);
            br    = ($urandom_range(0, 99) < 15);
            jmp   = ($urandom_range(0, 99) < 10);
            bt    = $urandom;
            jt    = $urandom;
            instr = ($urandom_range(0, 99) < 4) ? HW : $urandom_range(0, 32'h7FFF_FFFF);
            #1;
            exp_adv = (m_state == 1);
            check("rnd_adv", {31'd0, adv}, {31'd0, exp_adv});
            tick();
            if (exp_adv) begin
                m_cnt++;
                if (jmp)              m_pc = jt % 256;
                else if (br)          m_pc = bt % 256;
                else if (stall)       m_pc = m_pc;
                else if (instr == HW) m_state = 3;
                else                  m_pc = (m_pc + 1) % 256;
            end
            check("rnd_pc", pc, m_pc);
            check("rnd_state", {30'd0, state}, m_state);
            check("rnd_halted", {31'd0, halted}, (m_state == 3) ? 1 : 0);
            check("rnd_cnt", cnt, m_cnt[31:0]);
            $display("rnd %0d: pc=%0h state=%0d cnt=%0d", i, pc, state, cnt);
            if (m_state == 3) begin
                do_reset();
                start_run();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
